round_robin_arbiter: RTL and testbench
======================================

ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_CYCLES, default 16, the number of cycles a grant may be held before forced release (used only with TIMEOUT_EN).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port req, input, 4 bits, request lines, bit i = requester i.
REQ-005 The block SHALL have port done, input, 1 bit, release pulse from the current grant holder.
REQ-006 The block SHALL have port gnt, output, 4 bits, registered one-hot grant, or all-zero when nothing is granted; feeds the downstream 4:2 encoder W input.
REQ-007 The block SHALL have port busy, output, 1 bit, high while in GRANT state.
REQ-008 The block SHALL have port timeout, output, 1 bit, one-cycle pulse on forced release.

Function
REQ-009 The block SHALL implement two states: IDLE (gnt = 0000) and GRANT (gnt one-hot, held constant).
REQ-010 In IDLE with req != 0000, the block SHALL select the first set req bit searching ptr, ptr+1, ... modulo 4, load gnt with it and enter GRANT at the next edge (latency 1 cycle).
REQ-011 In IDLE with req == 0000, the block SHALL stay in IDLE with gnt = 0000; done SHALL be ignored.
REQ-012 In GRANT, the block SHALL hold gnt unchanged and ignore all req bits other than the granted one.
REQ-013 In GRANT, release SHALL occur when done = 1 or the granted req bit = 0; both in the same cycle counts as one release.
REQ-014 On release, the block SHALL clear gnt to 0000, set ptr = (granted index + 1) mod 4 and return to IDLE at the next edge.
REQ-015 The block SHALL keep gnt at 0000 for at least one cycle between consecutive grants.
REQ-016 The ptr wrap SHALL behave as follows: granted index 3 gives ptr 0.
REQ-017 A sole persistent requester SHALL be re-granted after each one-cycle idle gap.
REQ-018 gnt SHALL never have more than one bit set.
REQ-019 busy SHALL equal (state == GRANT), driven from a register.

Reset
REQ-020 When reset = 1 at a clock edge, the block SHALL set state = IDLE, gnt = 0000, busy = 0, timeout = 0, ptr = 0 and clear the watchdog counter.
REQ-021 reset SHALL take priority over every other input, including mid-grant; the next grant after reset SHALL search from index 0.

Configuration
REQ-022 With macro TIMEOUT_EN defined, the block SHALL count cycles spent in GRANT; if count reaches TIMEOUT_CYCLES without a release, it SHALL force release per REQ-014 and pulse timeout high for exactly that one cycle, coincident with gnt clearing.
REQ-023 With TIMEOUT_EN defined, the watchdog counter SHALL reset to 0 on every entry to GRANT.
REQ-024 With TIMEOUT_EN defined, a normal release in the same cycle the count is reached SHALL count as normal, with timeout = 0.
REQ-025 Without TIMEOUT_EN, the timeout port SHALL remain present and tied to 0, no counter SHALL be instantiated, and a grant SHALL be held indefinitely.

Verification
REQ-026 Scenario 1: after reset, req = 1111 held, done pulsed on each grant -> gnt sequence 0001, 0010, 0100, 1000, 0001, with 0000 between each grant.
REQ-027 Scenario 2: ptr = 2 (after a grant to 1 released), req = 1011 -> gnt = 1000 one cycle later.
REQ-028 Scenario 3: gnt = 0100, then req goes 1111 to 1011 with done = 1 in the same cycle -> single release, gnt = 0000 next cycle, then gnt = 1000.
REQ-029 Scenario 4: reset asserted while gnt = 0010 -> gnt = 0000 and busy = 0 next edge; with req = 1111 after reset, first grant is 0001.
REQ-030 Scenario 5 (TIMEOUT_EN, TIMEOUT_CYCLES = 16): req = 0001 held, done = 0 -> gnt = 0001 for 16 cycles, then gnt = 0000 with timeout = 1 for one cycle, then gnt = 0001 again.
REQ-031 Scenario 6: req = 0000 with done toggling -> gnt stays 0000, busy stays 0, timeout stays 0.

Source files
------------

// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter
//   Four-requester round-robin arbiter with a registered one-hot grant.
//   IDLE searches req starting at the rotating pointer; GRANT holds the
//   winner until done or its request drops, then returns to IDLE for at
//   least one cycle with the pointer advanced past the winner.
//
//   Optional feature: define macro TIMEOUT_EN to add a watchdog that forces
//   release after TIMEOUT_CYCLES cycles in GRANT and pulses timeout.
//   Without TIMEOUT_EN the timeout port is tied low and grants are held
//   indefinitely.
//
// Ports
//   clk     : clock, rising edge
//   reset   : synchronous, active-high
//   req     : request lines, bit i = requester i
//   done    : release pulse from the current grant holder
//   gnt     : registered one-hot grant (0000 when nothing is granted)
//   busy    : registered, high while in GRANT
//   timeout : one-cycle pulse on forced release (0 without TIMEOUT_EN)
module round_robin_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [1:0] gidx, gidx_nxt;   // index of the current grant holder
    logic [3:0] gnt_nxt;
    logic [1:0] cand;
    logic       found;
    logic       release_c;        // normal release requested by holder
    logic       expire;           // watchdog limit reached this cycle

    assign release_c = done || !req[gidx];

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        ptr_nxt   = ptr;
        gidx_nxt  = gidx;
        found     = 1'b0;
        cand      = '0;
        case (state)
            IDLE: begin
                gnt_nxt = '0;
                for (int unsigned i = 0; i < 4; i++) begin
                    cand = ptr + 2'(i);
                    if (!found && req[cand]) begin
                        found    = 1'b1;
                        gidx_nxt = cand;
                    end
                end
                if (found) begin
                    state_nxt = GRANT;
                    gnt_nxt   = 4'b0001 << gidx_nxt;
                end
            end
            GRANT: begin
                if (release_c || expire) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    ptr_nxt   = gidx + 2'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= '0;
            gidx  <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            busy  <= (state_nxt == GRANT);
            ptr   <= ptr_nxt;
            gidx  <= gidx_nxt;
        end
    end

`ifdef TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    // cnt holds k-1 during the k-th GRANT cycle, so the grant is visible
    // for exactly TIMEOUT_CYCLES cycles before the forced release.
    assign expire = (state == GRANT) && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            cnt     <= (state == GRANT) ? cnt + CW'(1) : '0;
            // a normal release on the limit cycle wins over the watchdog
            timeout <= expire && !release_c;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_round_robin_arbiter.sv
module tb_round_robin_arbiter;

    localparam int unsigned TC = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       busy;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;

    round_robin_arbiter #(.TIMEOUT_CYCLES(TC)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic       busy;
        logic       to;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] q, input logic d,
                       input logic [3:0] g, input logic b, input logic t);
        vec_t v;
        v.rst = r; v.req = q; v.done = d; v.gnt = g; v.busy = b; v.to = t;
        vecs.push_back(v);
    endtask

    // drive at negedge, clock it in, sample 1 time unit after the edge
    task automatic step(input logic r, input logic [3:0] q, input logic d);
        @(negedge clk);
        reset = r; req = q; done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] g, input logic b, input logic t);
        n_cmp++;
        if ({gnt, busy, timeout} !== {g, b, t}) begin
            n_bad++;
            $display("FAIL %s: got gnt=%b busy=%b timeout=%b, expected gnt=%b busy=%b timeout=%b",
                     name, gnt, busy, timeout, g, b, t);
        end
    endtask

    initial begin
        reset = 1'b1; req = '0; done = 1'b0;

        // reset and reset priority
        add(1, 4'b0000, 0, 4'b0000, 0, 0);
        add(1, 4'b1111, 0, 4'b0000, 0, 0);
        // full rotation with req=1111, done pulsed on each grant, wrap 3 -> 0
        add(0, 4'b1111, 0, 4'b0001, 1, 0);
        add(0, 4'b1111, 1, 4'b0000, 0, 0);
        add(0, 4'b1111, 0, 4'b0010, 1, 0);
        add(0, 4'b1111, 1, 4'b0000, 0, 0);
        add(0, 4'b1111, 0, 4'b0100, 1, 0);
        add(0, 4'b1111, 1, 4'b0000, 0, 0);
        add(0, 4'b1111, 0, 4'b1000, 1, 0);
        add(0, 4'b1111, 1, 4'b0000, 0, 0);
        add(0, 4'b1111, 0, 4'b0001, 1, 0);
        add(0, 4'b1111, 0, 4'b0001, 1, 0);   // held
        add(0, 4'b1111, 1, 4'b0000, 0, 0);   // ptr -> 1
        // grant to 1, release -> ptr 2; req=1011 picks 3
        add(0, 4'b0010, 0, 4'b0010, 1, 0);
        add(0, 4'b0010, 1, 4'b0000, 0, 0);
        add(0, 4'b1011, 0, 4'b1000, 1, 0);
        add(0, 4'b1011, 1, 4'b0000, 0, 0);   // ptr -> 0
        // grant to 2, others ignored, req drop + done together = one release
        add(0, 4'b0100, 0, 4'b0100, 1, 0);
        add(0, 4'b1111, 0, 4'b0100, 1, 0);
        add(0, 4'b1011, 1, 4'b0000, 0, 0);   // ptr -> 3
        add(0, 4'b1011, 0, 4'b1000, 1, 0);
        add(0, 4'b1011, 0, 4'b1000, 1, 0);
        add(0, 4'b0011, 0, 4'b0000, 0, 0);   // release by req drop, ptr -> 0
        add(0, 4'b0011, 0, 4'b0001, 1, 0);
        // reset mid-grant of requester 1, next grant searches from 0
        add(0, 4'b0011, 1, 4'b0000, 0, 0);   // ptr -> 1
        add(0, 4'b0011, 0, 4'b0010, 1, 0);
        add(1, 4'b1111, 0, 4'b0000, 0, 0);
        add(0, 4'b1111, 0, 4'b0001, 1, 0);
        // idle with done toggling
        add(1, 4'b0000, 0, 4'b0000, 0, 0);
        add(0, 4'b0000, 1, 4'b0000, 0, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 0);
        add(0, 4'b0000, 1, 4'b0000, 0, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 0);
        // sole persistent requester re-granted after one idle cycle
        add(0, 4'b0100, 0, 4'b0100, 1, 0);
        add(0, 4'b0100, 1, 4'b0000, 0, 0);
        add(0, 4'b0100, 0, 4'b0100, 1, 0);
        add(0, 4'b0100, 1, 4'b0000, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].done);
            check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].busy, vecs[i].to);
        end

`ifdef TIMEOUT_EN
        // watchdog: 16 cycles of grant, forced release with timeout pulse, re-grant
        step(1, 4'b0000, 0);
        check("wd_reset", 4'b0000, 0, 0);
        for (int i = 0; i < int'(TC); i++) begin
            step(0, 4'b0001, 0);
            check($sformatf("wd_hold%0d", i), 4'b0001, 1, 0);
        end
        step(0, 4'b0001, 0);
        check("wd_force", 4'b0000, 0, 1);
        step(0, 4'b0001, 0);
        check("wd_regrant", 4'b0001, 1, 0);
        // normal release on the limit cycle: no timeout pulse
        for (int i = 1; i < int'(TC); i++) begin
            step(0, 4'b0001, 0);
            check($sformatf("wd_hold2_%0d", i), 4'b0001, 1, 0);
        end
        step(0, 4'b0001, 1);
        check("wd_normal_at_limit", 4'b0000, 0, 0);
`else
        // without the watchdog a grant is held indefinitely
        step(1, 4'b0000, 0);
        check("hold_reset", 4'b0000, 0, 0);
        for (int i = 0; i < 40; i++) begin
            step(0, 4'b0001, 0);
            check($sformatf("hold%0d", i), 4'b0001, 1, 0);
        end
        step(0, 4'b0001, 1);
        check("hold_release", 4'b0000, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
